// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
package pipe_sched_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        DMEM_WAIT   = 2'd1,
        MD_WAIT     = 2'd2,
        FENCE_DRAIN = 2'd3
    } sched_state_t;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned WAIT_TIMEOUT_DEF = 1024;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/pipe_sched_if.sv
// Request inputs and stage-register controls between hazard logic and the scheduler.
interface pipe_sched_if #(
    parameter int unsigned PERF_W = 32
);
    logic              hz_stall;
    logic              hz_redirect;
    logic              fence_d;
    logic              dmem_req;
    logic              dmem_done;
    logic              md_start;
    logic              md_done;
    logic              stall_if_id;
    logic              stall_id_ex;
    logic              stall_ex_mem;
    logic              stall_mem_wb;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              flush_ex_mem;
    logic              flush_mem_wb;
    logic              busy;
    logic              timeout_err;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output hz_stall, hz_redirect, fence_d, dmem_req, dmem_done, md_start, md_done,
        input  stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
        input  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
        input  busy, timeout_err, stall_cycles
    );

    modport slave (
        input  hz_stall, hz_redirect, fence_d, dmem_req, dmem_done, md_start, md_done,
        output stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
        output flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
        output busy, timeout_err, stall_cycles
    );
endinterface

// File: rtl/pipe_sched_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_count = r_cnt;
endmodule

// File: rtl/pipe_sched.sv
// Merges hazard, dmem, mul/div and fence requests into prioritised stage stalls/flushes,
// holding a redirect seen during a stall until the first unstalled RUN cycle.
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
    parameter int unsigned PERF_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_sched_if.slave sif
);
    localparam int unsigned DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int unsigned TO_LIM     = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT : 1;
    localparam int unsigned TW         = $clog2(TO_LIM + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_LIM - 1);

    sched_state_t r_state, w_next;
    logic [DW-1:0] r_drain;
    logic          r_pend;
    logic          r_timeout_err;

    logic w_s_if, w_s_id, w_s_ex, w_s_mw;
    logic w_f_if, w_f_id, w_f_ex, w_f_mw;
    logic w_drain_load, w_drain_dec;
    logic w_waiting;
    logic [TW-1:0]     w_to_cnt;
    logic [PERF_W-1:0] w_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_s_if       = DISABLE;
        w_s_id       = DISABLE;
        w_s_ex       = DISABLE;
        w_s_mw       = DISABLE;
        w_f_if       = DISABLE;
        w_f_id       = DISABLE;
        w_f_ex       = DISABLE;
        w_f_mw       = DISABLE;
        w_drain_load = DISABLE;
        w_drain_dec  = DISABLE;
        unique case (r_state)
            RUN: begin
                if (sif.dmem_req && !sif.dmem_done) begin
                    {w_s_if, w_s_id, w_s_ex, w_f_mw} = '1;
                    w_next = DMEM_WAIT;
                end else if (sif.md_start && !sif.md_done) begin
                    {w_s_if, w_s_id, w_f_ex} = '1;
                    w_next = MD_WAIT;
                end else if (sif.hz_stall) begin
                    // load-use bubble: hold IF/ID, squash into ID/EX rather than holding it
                    {w_s_if, w_f_id} = '1;
                end else if (sif.fence_d && (DRAIN_CYCLES != 0)) begin
                    {w_s_if, w_f_id} = '1;
                    w_drain_load = ENABLE;
                    w_next = FENCE_DRAIN;
                end else if (sif.hz_redirect || r_pend) begin
                    w_f_if = ENABLE;
                end
            end
            DMEM_WAIT: begin
                if (sif.dmem_done) begin
                    w_next = RUN;
                end else begin
                    {w_s_if, w_s_id, w_s_ex, w_f_mw} = '1;
                end
            end
            MD_WAIT: begin
                if (sif.md_done) begin
                    w_next = RUN;
                end else begin
                    {w_s_if, w_s_id, w_f_ex} = '1;
                end
            end
            FENCE_DRAIN: begin
                if (r_drain == '0) begin
                    w_next = RUN;
                end else begin
                    {w_s_if, w_f_id} = '1;
                    w_drain_dec = ENABLE;
                end
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain <= '0;
        end else if (w_drain_load) begin
            r_drain <= DW'(DRAIN_LOAD);
        end else if (w_drain_dec) begin
            r_drain <= r_drain - DW'(1);
        end
    end

    // Any redirect not turned into a flush this cycle is held; the flush itself retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= (r_pend | sif.hz_redirect) & ~w_f_if;
        end
    end

    assign w_waiting = (r_state == DMEM_WAIT) || (r_state == MD_WAIT);

    sat_counter #(.W(TW)) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_waiting),
        .i_clr   (!w_waiting),
        .o_count (w_to_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_waiting && (w_to_cnt >= TO_LAST)) begin
            r_timeout_err <= 1'b1;
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_s_if),
        .i_clr   (DISABLE),
        .o_count (w_stall_cycles)
    );

    // Reset gates the controls so inputs held during reset cannot leak through.
    assign sif.stall_if_id  = w_s_if & rst_n;
    assign sif.stall_id_ex  = w_s_id & rst_n;
    assign sif.stall_ex_mem = w_s_ex & rst_n;
    assign sif.stall_mem_wb = w_s_mw & rst_n;
    assign sif.flush_if_id  = w_f_if & rst_n;
    assign sif.flush_id_ex  = w_f_id & rst_n;
    assign sif.flush_ex_mem = w_f_ex & rst_n;
    assign sif.flush_mem_wb = w_f_mw & rst_n;
    assign sif.busy         = (r_state != RUN);
    assign sif.timeout_err  = r_timeout_err;
    assign sif.stall_cycles = w_stall_cycles;
endmodule

// File: tb/tb_pipe_sched.sv
// Directed scoreboard bench: stimulus queues expected controls, a negedge monitor checks them.
module tb_pipe_sched;
    localparam int unsigned PW = 32;

    // stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb
    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] S_DMEM = 8'b1110_0001;
    localparam logic [7:0] S_MD   = 8'b1100_0010;
    localparam logic [7:0] S_HZ   = 8'b1000_0100;
    localparam logic [7:0] S_FN   = 8'b1000_0100;
    localparam logic [7:0] F_IF   = 8'b0000_1000;

    // hz_stall, hz_redirect, fence_d, dmem_req, dmem_done, md_start, md_done
    localparam logic [6:0] I_0  = 7'b0000000;
    localparam logic [6:0] I_HZ = 7'b1000000;
    localparam logic [6:0] I_RD = 7'b0100000;
    localparam logic [6:0] I_FN = 7'b0010000;
    localparam logic [6:0] I_DR = 7'b0001000;
    localparam logic [6:0] I_DD = 7'b0000100;
    localparam logic [6:0] I_MS = 7'b0000010;
    localparam logic [6:0] I_MD = 7'b0000001;

    typedef struct {
        string      nm;
        logic [7:0] sf;
        logic       bsy;
        logic       terr;
        int         scyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;

    pipe_sched_if #(.PERF_W(PW)) bus ();

    pipe_sched #(
        .DRAIN_CYCLES (3),
        .WAIT_TIMEOUT (8),
        .PERF_W       (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e = sb.pop_front();
            got = {bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem, bus.stall_mem_wb,
                   bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.flush_mem_wb};
            checks++;
            if ({got, bus.busy, bus.timeout_err} !== {e.sf, e.bsy, e.terr}) begin
                fails++;
                $display("FAIL %s: got ctl=%b busy=%b terr=%b, expected ctl=%b busy=%b terr=%b",
                         e.nm, got, bus.busy, bus.timeout_err, e.sf, e.bsy, e.terr);
            end
            if (e.scyc >= 0) begin
                checks++;
                if (bus.stall_cycles !== PW'(e.scyc)) begin
                    fails++;
                    $display("FAIL %s_stall_cycles: got %0d, expected %0d",
                             e.nm, bus.stall_cycles, e.scyc);
                end
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [6:0] in,
                        input logic [7:0] sf, input logic bsy, input logic terr, input int scyc);
        exp_t e;
        rst_n = r;
        {bus.hz_stall, bus.hz_redirect, bus.fence_d, bus.dmem_req,
         bus.dmem_done, bus.md_start, bus.md_done} = in;
        e.nm = nm; e.sf = sf; e.bsy = bsy; e.terr = terr; e.scyc = scyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        {bus.hz_stall, bus.hz_redirect, bus.fence_d, bus.dmem_req,
         bus.dmem_done, bus.md_start, bus.md_done} = I_0;
        repeat (2) @(posedge clk);
        #1;
        step("reset_idle", 1'b1, I_0, NONE, 1'b0, 1'b0, 0);

        step("dmem_c0", 1'b1, I_DR,        S_DMEM, 1'b0, 1'b0, 0);
        step("dmem_c1", 1'b1, I_DR,        S_DMEM, 1'b1, 1'b0, 1);
        step("dmem_c2", 1'b1, I_DR,        S_DMEM, 1'b1, 1'b0, 2);
        step("dmem_c3", 1'b1, I_DR,        S_DMEM, 1'b1, 1'b0, 3);
        step("dmem_c4", 1'b1, I_DR | I_DD, NONE,   1'b1, 1'b0, 4);
        step("dmem_c5", 1'b1, I_0,         NONE,   1'b0, 1'b0, 4);

        step("prio_c0", 1'b1, I_DR | I_MS, S_DMEM, 1'b0, 1'b0, 4);
        step("prio_c1", 1'b1, I_DR | I_DD, NONE,   1'b1, 1'b0, 5);
        step("prio_c2", 1'b1, I_0,         NONE,   1'b0, 1'b0, 5);

        step("fence_c0", 1'b1, I_FN, S_FN, 1'b0, 1'b0, 5);
        step("fence_c1", 1'b1, I_FN, S_FN, 1'b1, 1'b0, 6);
        step("fence_c2", 1'b1, I_FN, S_FN, 1'b1, 1'b0, 7);
        step("fence_c3", 1'b1, I_FN, NONE, 1'b1, 1'b0, 8);
        step("fence_c4", 1'b1, I_0,  NONE, 1'b0, 1'b0, 8);

        step("hz_c0", 1'b1, I_HZ, S_HZ, 1'b0, 1'b0, 8);
        step("hz_c1", 1'b1, I_0,  NONE, 1'b0, 1'b0, 9);

        step("redir_c0", 1'b1, I_RD, F_IF, 1'b0, 1'b0, 9);
        step("redir_c1", 1'b1, I_0,  NONE, 1'b0, 1'b0, 9);

        step("md_c0", 1'b1, I_MS,        S_MD, 1'b0, 1'b0, 9);
        step("md_c1", 1'b1, I_MS,        S_MD, 1'b1, 1'b0, 10);
        step("md_c2", 1'b1, I_MS | I_RD, S_MD, 1'b1, 1'b0, 11);
        step("md_c3", 1'b1, I_MS,        S_MD, 1'b1, 1'b0, 12);
        step("md_c4", 1'b1, I_MS,        S_MD, 1'b1, 1'b0, 13);
        step("md_c5", 1'b1, I_MS | I_MD, NONE, 1'b1, 1'b0, 14);
        step("md_c6", 1'b1, I_0,         F_IF, 1'b0, 1'b0, 14);
        step("md_c7", 1'b1, I_0,         NONE, 1'b0, 1'b0, 14);

        step("dmem_same_cycle", 1'b1, I_DR | I_DD, NONE, 1'b0, 1'b0, 14);
        step("md_same_cycle",   1'b1, I_MS | I_MD, NONE, 1'b0, 1'b0, 14);

        step("to_c0", 1'b1, I_DR, S_DMEM, 1'b0, 1'b0, 14);
        for (int k = 1; k <= 10; k++) begin
            step("to_wait", 1'b1, I_DR, S_DMEM, 1'b1, (k >= 9) ? 1'b1 : 1'b0, 14 + k);
        end
        step("reset_mid",  1'b0, I_DR, NONE, 1'b0, 1'b0, 0);
        step("post_reset", 1'b1, I_0,  NONE, 1'b0, 1'b0, 0);
        step("post_idle",  1'b1, I_0,  NONE, 1'b0, 1'b0, 0);

        for (int n = 0; n < 5 && sb.size() > 0; n++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
